// File: rtl/dac_sdm_driver.sv
// Sample FIFO feeding a first-order sigma-delta modulator: one sample is consumed every OSR
// clocks, and the ones-density of dac_out tracks sample/2^DATA_W.
module dac_sdm_driver #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OSR        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             din,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic                          underflow_clr,
  output logic                          dac_out,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(OSR);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  acc, acc_nxt;
  logic [DATA_W-1:0]  cur, cur_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               dac_nxt;
  logic [DATA_W:0]    acc_sum;
  logic               pop, push, uf_set, full, empty;

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;

  assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign empty     = (fifo_level == '0);
  assign din_ready = !full;
  assign push      = din_valid && !full;

  // Storage carries no reset: contents are meaningless once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cur       <= '0;
      cnt       <= '0;
      dac_out   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cur       <= cur_nxt;
      cnt       <= cnt_nxt;
      dac_out   <= dac_nxt;
      underflow <= uf_set | (underflow & ~underflow_clr);
    end
  end

  // Carry out of the accumulator is the output bit.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cur_nxt   = cur;
    cnt_nxt   = cnt;
    dac_nxt   = dac_out;
    pop       = 1'b0;
    uf_set    = 1'b0;
    acc_sum   = {1'b0, acc} + {1'b0, cur};
    case (state)
      IDLE: begin
        acc_nxt = '0;
        cnt_nxt = '0;
        dac_nxt = 1'b0;
        if (enable) state_nxt = PRIME;
      end
      PRIME: begin
        dac_nxt = 1'b0;
        if (!enable) begin
          state_nxt = IDLE;
        end else if (!empty) begin
          pop       = 1'b1;
          cur_nxt   = mem[rd_ptr];
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          dac_nxt   = 1'b0;
        end else begin
          acc_nxt = acc_sum[DATA_W-1:0];
          dac_nxt = acc_sum[DATA_W];
          if (cnt == CNT_W'(OSR - 1)) begin
            cnt_nxt = '0;
            if (!empty) begin
              pop     = 1'b1;
              cur_nxt = mem[rd_ptr];
            end else begin
              uf_set = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
